// File: rtl/johnson_phase_monitor_if.sv
// Signal bundle between a Johnson-code source and the phase monitor.
// The master drives the code samples; the slave (monitor) returns decoded phase and status.
interface johnson_phase_monitor_if #(
    parameter int WIDTH = 4,
    parameter int PH_W  = 3,
    parameter int REV_W = 8
);
    logic [WIDTH-1:0]   din;
    logic               din_vld;
    logic               err_clr;
    logic [PH_W-1:0]    phase;
    logic [2*WIDTH-1:0] phase_onehot;
    logic               code_ok;
    logic               locked;
    logic               step_err;
    logic               err_sticky;
    logic [REV_W-1:0]   rev_cnt;

    modport master (
        output din, din_vld, err_clr,
        input  phase, phase_onehot, code_ok, locked, step_err, err_sticky, rev_cnt
    );

    modport slave (
        input  din, din_vld, err_clr,
        output phase, phase_onehot, code_ok, locked, step_err, err_sticky, rev_cnt
    );
endinterface

// File: rtl/johnson_phase_monitor.sv
// Decodes a Johnson counter code into a phase index, checks code/step legality,
// tracks lock and counts revolutions completed while locked.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// UNLOCKED | waiting for the first legal code; illegal codes ignored silently
// ACQUIRE  | counting consecutive legal forward steps towards lock
// LOCKED   | sequence tracked; any illegal code or step drops lock
module johnson_phase_monitor #(
    parameter int WIDTH      = 4,
    parameter int PH_W       = 3,
    parameter int LOCK_CNT   = 3,
    parameter bit ALLOW_HOLD = 1'b0,
    parameter int REV_W      = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    johnson_phase_monitor_if.slave      mon
);

    localparam int            SEQ_LEN = 2 * WIDTH;
    localparam logic [PH_W-1:0] LAST_PH = PH_W'(SEQ_LEN - 1);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    state_t             state_q;
    logic [3:0]         steps_left_q;
    logic [PH_W-1:0]    phase_q;
    logic [SEQ_LEN-1:0] onehot_q;
    logic               code_ok_q;
    logic               locked_q;
    logic               step_err_q;
    logic               err_sticky_q;
    logic [REV_W-1:0]   rev_cnt_q;

    logic               code_legal;
    logic [PH_W-1:0]    code_phase;
    logic [SEQ_LEN-1:0] code_onehot;
    logic [PH_W-1:0]    next_phase;
    logic               step_fwd;
    logic               step_hold_ok;
    logic               step_good;
    logic               err_d;

    // MSB-fill Johnson code for phase k: k ones from the MSB up to WIDTH,
    // then zeros filling in from the MSB.
    function automatic logic [WIDTH-1:0] johnson_code(input int k);
        logic [WIDTH-1:0] ones;
        ones = '1;
        if (k <= WIDTH) begin
            return ~(ones >> k);
        end
        return ones >> (k - WIDTH);
    endfunction

    always_comb begin
        code_legal  = 1'b0;
        code_phase  = '0;
        for (int k = 0; k < SEQ_LEN; k++) begin
            if (mon.din == johnson_code(k)) begin
                code_legal = 1'b1;
                code_phase = PH_W'(k);
            end
        end
        code_onehot             = '0;
        code_onehot[code_phase] = code_legal;
    end

    always_comb begin
        next_phase   = (phase_q == LAST_PH) ? '0 : phase_q + 1'b1;
        step_fwd     = code_legal && (code_phase == next_phase);
        step_hold_ok = ALLOW_HOLD && code_legal && (code_phase == phase_q);
        step_good    = step_fwd || step_hold_ok;
        err_d        = mon.din_vld && (state_q != UNLOCKED) && !step_good;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= UNLOCKED;
            steps_left_q <= '0;
            phase_q      <= '0;
            onehot_q     <= '0;
            code_ok_q    <= 1'b0;
            locked_q     <= 1'b0;
            step_err_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            rev_cnt_q    <= '0;
        end else begin
            step_err_q <= err_d;

            // Set beats clear when an error and err_clr land on the same sample.
            if (err_d) begin
                err_sticky_q <= 1'b1;
            end else if (mon.err_clr) begin
                err_sticky_q <= 1'b0;
            end

            if (mon.din_vld) begin
                code_ok_q <= code_legal;
                onehot_q  <= code_onehot;
                if (code_legal) begin
                    phase_q <= code_phase;
                end

                unique case (state_q)
                    UNLOCKED: begin
                        if (code_legal) begin
                            state_q      <= ACQUIRE;
                            steps_left_q <= 4'(LOCK_CNT);
                        end
                    end
                    ACQUIRE: begin
                        if (step_fwd) begin
                            steps_left_q <= steps_left_q - 4'd1;
                            if (steps_left_q == 4'd1) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end
                        end else if (!step_hold_ok) begin
                            state_q <= UNLOCKED;
                        end
                    end
                    LOCKED: begin
                        if (step_fwd) begin
                            if ((phase_q == LAST_PH) && (rev_cnt_q != '1)) begin
                                rev_cnt_q <= rev_cnt_q + 1'b1;
                            end
                        end else if (!step_hold_ok) begin
                            state_q  <= UNLOCKED;
                            locked_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q  <= UNLOCKED;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign mon.phase        = phase_q;
    assign mon.phase_onehot = onehot_q;
    assign mon.code_ok      = code_ok_q;
    assign mon.locked       = locked_q;
    assign mon.step_err     = step_err_q;
    assign mon.err_sticky   = err_sticky_q;
    assign mon.rev_cnt      = rev_cnt_q;

endmodule

// File: doc/johnson_phase_monitor.md
Name: johnson_phase_monitor

Overview:
- Downstream consumer of the 4-bit Johnson counter output.
- Samples the counter's dout each valid cycle, decodes it to a binary phase index and a one-hot phase, and checks every code and every step for legality.
- Tracks lock state and counts full revolutions.
- Feeds phase-sequenced control logic and raises errors on corrupted or skipped counter states.

Parameters:
- WIDTH, 4, Johnson code width; sequence length is 2*WIDTH.
- PH_W, 3, width of binary phase index; must equal ceil(log2(2*WIDTH)).
- LOCK_CNT, 3, consecutive legal forward steps required to declare lock (1..15).
- ALLOW_HOLD, 0, 1 = a repeated code on a valid sample is legal (stall); 0 = repeat is a step error.
- REV_W, 8, revolution counter width.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- din  input  WIDTH  Johnson code from upstream counter (dout)
- din_vld  input  1  din sample valid this cycle
- err_clr  input  1  clears err_sticky
- phase  output  PH_W  decoded phase index of last valid sample
- phase_onehot  output  2*WIDTH  one-hot of phase; all zero when last code illegal
- code_ok  output  1  last valid sample was a legal Johnson code
- locked  output  1  monitor in LOCKED state
- step_err  output  1  one-cycle pulse on illegal code or illegal step while ACQUIRE/LOCKED
- err_sticky  output  1  set by step_err, held until err_clr or rst
- rev_cnt  output  REV_W  completed revolutions while locked, saturating

Behaviour:
- Code map, MSB-fill order: phase k (0..WIDTH) = k ones from the MSB, rest zeros; phase WIDTH+j (j=1..WIDTH-1) = j zeros from the MSB, rest ones. For WIDTH=4: 0000=0, 1000=1, 1100=2, 1110=3, 1111=4, 0111=5, 0011=6, 0001=7. Any other pattern is illegal.
- All outputs registered; one-cycle latency from a din_vld sample to phase/phase_onehot/code_ok/step_err.
- din_vld=0: no state, output, or counter change; step_err=0.
- Legal step: new phase = (prev phase + 1) mod 2*WIDTH. A repeat is also legal only when ALLOW_HOLD=1. A reverse step or skip is illegal.
- Illegal code: code_ok=0, phase holds its previous value, phase_onehot=0.
- FSM states:
  - UNLOCKED (reset state): first legal code stores phase, goes to ACQUIRE, step counter=0. An illegal code stays in UNLOCKED with no step_err.
  - ACQUIRE: each legal forward step increments the step counter; reaching LOCK_CNT goes to LOCKED. A legal hold leaves the counter unchanged. Illegal code or step: step_err pulse, back to UNLOCKED.
  - LOCKED: legal step stays. Illegal code or step: step_err pulse, locked drops on the same output update, go to UNLOCKED.
- rev_cnt increments when locked=1 and a legal step goes from phase 2*WIDTH-1 to 0. It saturates at all-ones and holds its value across loss of lock; only rst clears it.
- err_sticky: set on step_err. err_clr clears it. If err_clr and step_err occur in the same cycle, set wins.
- Reset values: phase=0, phase_onehot=0, code_ok=0, locked=0, step_err=0, err_sticky=0, rev_cnt=0, FSM=UNLOCKED, step counter=0.
- Reset mid-operation: rst has priority over all inputs. The next valid sample is treated as the first.

Test Plan:
- rst=1 two cycles, then rst=0 with free-running din 0000,1000,1100,... every cycle with din_vld=1 -> phase 0,1,2,... one cycle later; locked rises after sample 4 (1+LOCK_CNT); step_err stays 0.
- Locked, full cycle 0001->0000 -> rev_cnt increments 0->1. Force rev_cnt to 255 via 255 wraps -> stays 255 after the next wrap.
- Locked at phase 2 (1100), inject din=1010 -> code_ok=0, phase_onehot=0, step_err one pulse, locked=0, err_sticky=1. err_clr pulse -> err_sticky=0.
- Locked at phase 3, inject skip to 0111 (phase 5) -> step_err pulse, unlock. Resume legal sequence -> relock after LOCK_CNT steps.
- ALLOW_HOLD=0: repeat 1110 with din_vld=1 -> step_err. ALLOW_HOLD=1: same repeat -> no error, lock held. din_vld=0 for 5 cycles -> all outputs frozen.
- Assert rst while locked with rev_cnt=3 -> next cycle all outputs zero, FSM UNLOCKED. Step_err and err_clr in the same cycle -> err_sticky=1.
